dc_token_rx_channel: RTL and testbench
======================================

// Module: dc_token_rx_channel
// PURPOSE
//  Destination (reader) end of one writetoken/readpointer channel of the SoC<->cluster AXI CDC link.
//  Counterpart of the source side, which drives *_writetoken_o plus buffer data and consumes *_readpointer_i.
//  - Synchronises the incoming write-token ring.
//  - Reads buffer slots in order and presents them as a registered valid/ready stream.
//  - Returns the read-pointer ring to the source.
//  - Instantiated once per AXI channel (AW/AR/W/R/B) on the receiving clock domain.
// PARAMETERS
//  BUFFER_WIDTH  8   number of buffer slots = bits in writetoken/readpointer rings (>=2)
//  DATA_WIDTH    64  payload bits per slot (whole flattened AXI beat)
//  SYNC_STAGES   2   flops in token synchroniser (>=2)
// PORTS
//  clk_i           in   1                        receiving-domain clock
//  rst_i           in   1                        reset, synchronous, active-high
//  writetoken_i    in   BUFFER_WIDTH             write-token ring from source (asynchronous)
//  buffer_data_i   in   BUFFER_WIDTH*DATA_WIDTH  source slot storage; slot k = bits [k*DATA_WIDTH +: DATA_WIDTH]
//  readpointer_o   out  BUFFER_WIDTH             read-pointer ring back to source
//  data_o          out  DATA_WIDTH               registered payload
//  valid_o         out  1                        data_o valid
//  ready_i         in   1                        downstream accepts data_o
//  fill_o          out  $clog2(BUFFER_WIDTH+1)   slots full as seen after sync (excludes output reg)
// BEHAVIOUR
//  Clock and reset
//   - One clock: clk_i. Reset rst_i is synchronous and active-high.
//   - Reset values: readpointer_o=0, data_o=0, valid_o=0, fill_o=0, sync flops=0, rd_idx=0.
//  Slot protocol
//   - Slot k is full iff tok_s[k] ^ readpointer_o[k] == 1, where tok_s is the synchronised writetoken_i.
//   - Source toggles writetoken[k] only after slot k data is stable.
//   - Source holds slot k data until it sees readpointer[k] toggle back into agreement.
//  Read index
//   - rd_idx counts 0..BUFFER_WIDTH-1 and wraps to 0. Slots are consumed strictly in this order.
//  Output stage FSM (2 states)
//   - EMPTY (valid_o=0): if slot rd_idx is full -> load, go FULL.
//   - FULL (valid_o=1):
//     - ready_i=1 and slot rd_idx full -> reload in the same cycle, stay FULL.
//     - ready_i=1 and slot rd_idx empty -> go EMPTY.
//     - ready_i=0 -> hold; data_o stable.
//  Load action (single cycle)
//   - data_o <= slot rd_idx.
//   - readpointer_o[rd_idx] toggles.
//   - rd_idx <= rd_idx+1 (mod BUFFER_WIDTH).
//  Latency and throughput
//   - writetoken_i edge at cycle t -> tok_s at t+SYNC_STAGES -> valid_o=1 at t+SYNC_STAGES+1.
//   - Throughput is 1 beat/cycle with ready_i held high and the ring fed.
//  Handshake rules
//   - valid_o never drops without a ready_i handshake; data_o changes only on load.
//   - readpointer_o is driven directly from flops (CDC-safe, no glitches).
//   - At most one readpointer_o bit toggles per cycle.
//  Boundary conditions
//   - Ring full (all BUFFER_WIDTH slots full): no special case; drains in order.
//   - Wrap: slot BUFFER_WIDTH-1 is followed by slot 0.
//   - Token toggle on a slot other than rd_idx: waits until rd_idx reaches it (no reordering).
//   - fill_o = popcount(tok_s ^ readpointer_o), updated every cycle.
//   - Reset mid-transfer: all state is cleared and in-flight beats are discarded. Source must be reset together.
// TESTING
//  1. Reset, toggle writetoken_i[0] with slot0=64'hDEAD_BEEF_0000_0001, ready_i=1
//     -> valid_o rises exactly 3 cycles later, data_o=slot0.
//     -> readpointer_o=8'h01 in that same cycle; valid_o drops next cycle.
//  2. Fill all 8 slots (tokens 8'hFF), ready_i=1
//     -> 8 consecutive valid beats in order slot0..slot7.
//     -> readpointer_o ends 8'hFF; fill_o goes 8->0.
//  3. Back-pressure: 3 slots full, ready_i=0 for 10 cycles
//     -> data_o/valid_o stable, readpointer_o=8'h01, fill_o=2.
//     -> release ready_i: remaining beats drain 1/cycle.
//  4. Wrap: stream 20 beats with a second token lap (bits toggle back to 0)
//     -> beats 9..16 come from slots 0..7 again.
//     -> readpointer_o returns to 8'h00 after 16 pops; no beat lost or duplicated.
//  5. Out-of-order token: toggle writetoken_i[2] only (rd_idx=0)
//     -> no valid_o; fill_o=1.
//     -> then toggle [0],[1] -> beats emerge in order 0,1,2.
//  6. Assert rst_i with 4 beats pending and valid_o=1
//     -> next cycle valid_o=0, readpointer_o=0, rd_idx=0, fill_o=0.

Source files
------------

// File: rtl/dc_token_rx_channel_if.sv
// Reader-side bundle of one token CDC channel: token ring in, slot data in, pointer ring out, output stream.
// Latency: none, wires only.
// Backpressure: carried by ready_i against valid_o on the output stream.
interface dc_token_rx_channel_if #(
    parameter int BUFFER_WIDTH = 8,
    parameter int DATA_WIDTH   = 64
);
    localparam int FILL_W = $clog2(BUFFER_WIDTH + 1);

    logic [BUFFER_WIDTH-1:0]            writetoken_i;
    logic [BUFFER_WIDTH*DATA_WIDTH-1:0] buffer_data_i;
    logic [BUFFER_WIDTH-1:0]            readpointer_o;
    logic [DATA_WIDTH-1:0]              data_o;
    logic                               valid_o;
    logic                               ready_i;
    logic [FILL_W-1:0]                  fill_o;

    // Source + downstream consumer side
    modport master (
        output writetoken_i, buffer_data_i, ready_i,
        input  readpointer_o, data_o, valid_o, fill_o
    );

    // Channel reader side
    modport slave (
        input  writetoken_i, buffer_data_i, ready_i,
        output readpointer_o, data_o, valid_o, fill_o
    );
endinterface

// File: rtl/dc_token_rx_channel.sv
// Reader end of a writetoken/readpointer CDC channel: syncs token ring, pops slots in order into a registered stream.
// Latency: token edge -> valid_o after SYNC_STAGES+1 cycles; 1 beat/cycle sustained.
// Backpressure: ready_i low holds valid_o/data_o; no new slot is consumed, so the source stalls on its ring.
module dc_token_rx_channel #(
    parameter int BUFFER_WIDTH = 8,
    parameter int DATA_WIDTH   = 64,
    parameter int SYNC_STAGES  = 2
) (
    input logic                  clk_i,
    input logic                  rst_i,
    dc_token_rx_channel_if.slave ch
);
    localparam int IDX_W  = $clog2(BUFFER_WIDTH);
    localparam int FILL_W = $clog2(BUFFER_WIDTH + 1);

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t                  state_q, state_d;
    logic [BUFFER_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [BUFFER_WIDTH-1:0] tok_s;
    logic [BUFFER_WIDTH-1:0] pending;
    logic [BUFFER_WIDTH-1:0] rdptr_q, rdptr_d;
    logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   slot_dat [BUFFER_WIDTH];
    logic                    slot_full;
    logic                    load;
    logic [FILL_W-1:0]       fill;

    // Multi-flop synchroniser for the asynchronous write-token ring
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= ch.writetoken_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign tok_s     = sync_q[SYNC_STAGES-1];
    assign pending   = tok_s ^ rdptr_q;
    assign slot_full = pending[rd_idx_q];

    // Split the flat slot storage into addressable slots
    always_comb begin
        for (int k = 0; k < BUFFER_WIDTH; k++) begin
            slot_dat[k] = ch.buffer_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Output-stage FSM: decide when the current slot is moved into the output register
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (slot_full) begin
                    load    = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (ch.ready_i) begin
                    if (slot_full) load    = 1'b1;
                    else           state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Load action: capture slot, hand it back to the source, advance the read index
    always_comb begin
        data_d   = data_q;
        rdptr_d  = rdptr_q;
        rd_idx_d = rd_idx_q;
        if (load) begin
            data_d   = slot_dat[rd_idx_q];
            rdptr_d  = rdptr_q ^ (BUFFER_WIDTH'(1) << rd_idx_q);
            rd_idx_d = (rd_idx_q == IDX_W'(BUFFER_WIDTH - 1)) ? '0 : rd_idx_q + 1'b1;
        end
    end

    // State, payload, pointer ring and read index registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_EMPTY;
            data_q   <= '0;
            rdptr_q  <= '0;
            rd_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            rdptr_q  <= rdptr_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    // Occupancy as seen after sync; excludes the beat parked in the output register
    always_comb begin
        fill = '0;
        for (int k = 0; k < BUFFER_WIDTH; k++) begin
            fill = fill + FILL_W'(pending[k]);
        end
    end

    assign ch.readpointer_o = rdptr_q;
    assign ch.data_o        = data_q;
    assign ch.valid_o       = (state_q == ST_FULL);
    assign ch.fill_o        = fill;
endmodule

// File: tb/tb_dc_token_rx_channel.sv
module tb_dc_token_rx_channel;
    localparam int BW = 8;
    localparam int DW = 64;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [DW-1:0] exp_q [$];
    int            src_idx;

    always #5 clk = ~clk;

    dc_token_rx_channel_if #(.BUFFER_WIDTH(BW), .DATA_WIDTH(DW)) ch ();

    dc_token_rx_channel #(
        .BUFFER_WIDTH(BW),
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .ch   (ch)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_dat();
        return {$urandom, $urandom};
    endfunction

    // Source model: publish data in slot k, then flip its token
    task automatic push_slot(input int k, input logic [DW-1:0] d);
        ch.buffer_data_i[k*DW +: DW] = d;
        ch.writetoken_i[k] = ~ch.writetoken_i[k];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ch.writetoken_i  = '0;
        ch.ready_i       = 1'b0;
        for (int k = 0; k < BW; k++) ch.buffer_data_i[k*DW +: DW] = rand_dat();
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        src_idx = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ch.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", ch.valid_o); end
        total++; if (ch.data_o !== '0) begin bad++; $display("FAIL reset_data: got %h expected 0", ch.data_o); end
        total++; if (ch.readpointer_o !== '0) begin bad++; $display("FAIL reset_rdptr: got %h expected 00", ch.readpointer_o); end
        total++; if (ch.fill_o !== '0) begin bad++; $display("FAIL reset_fill: got %0d expected 0", ch.fill_o); end
    endtask

    task automatic test_latency();
        logic [DW-1:0] d0;
        d0 = 64'hDEAD_BEEF_0000_0001;
        do_reset();
        ch.ready_i = 1'b1;
        push_slot(0, d0);
        tick();
        total++; if (ch.valid_o !== 1'b0) begin bad++; $display("FAIL lat_early1: valid got %b expected 0", ch.valid_o); end
        tick();
        total++; if (ch.valid_o !== 1'b0) begin bad++; $display("FAIL lat_early2: valid got %b expected 0", ch.valid_o); end
        total++; if (ch.fill_o !== 4'd1) begin bad++; $display("FAIL lat_fill_synced: got %0d expected 1", ch.fill_o); end
        tick();
        total++; if (ch.valid_o !== 1'b1) begin bad++; $display("FAIL lat_valid3: got %b expected 1", ch.valid_o); end
        total++; if (ch.data_o !== d0) begin bad++; $display("FAIL lat_data: got %h expected %h", ch.data_o, d0); end
        total++; if (ch.readpointer_o !== 8'h01) begin bad++; $display("FAIL lat_rdptr: got %h expected 01", ch.readpointer_o); end
        total++; if (ch.fill_o !== 4'd0) begin bad++; $display("FAIL lat_fill_after: got %0d expected 0", ch.fill_o); end
        tick();
        total++; if (ch.valid_o !== 1'b0) begin bad++; $display("FAIL lat_drop: valid got %b expected 0", ch.valid_o); end
    endtask

    task automatic test_full_ring();
        logic [DW-1:0] e;
        int beats, first, last, maxfill;
        do_reset();
        ch.ready_i = 1'b1;
        for (int k = 0; k < BW; k++) begin
            e = rand_dat();
            push_slot(k, e);
            exp_q.push_back(e);
        end
        beats = 0; first = -1; last = -1; maxfill = 0;
        for (int c = 0; c < 30; c++) begin
            if (int'(ch.fill_o) > maxfill) maxfill = int'(ch.fill_o);
            if (ch.valid_o === 1'b1) begin
                if (first < 0) first = c;
                last = c;
                beats++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL ring_extra_beat: got %h expected none", ch.data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (ch.data_o !== e) begin bad++; $display("FAIL ring_data: beat %0d got %h expected %h", beats, ch.data_o, e); end
                end
            end
            tick();
        end
        total++; if (beats != BW) begin bad++; $display("FAIL ring_count: got %0d expected %0d", beats, BW); end
        total++; if (last - first != BW - 1) begin bad++; $display("FAIL ring_b2b: span got %0d expected %0d", last - first, BW - 1); end
        total++; if (maxfill != BW) begin bad++; $display("FAIL ring_maxfill: got %0d expected %0d", maxfill, BW); end
        total++; if (ch.fill_o !== '0) begin bad++; $display("FAIL ring_fill_end: got %0d expected 0", ch.fill_o); end
        total++; if (ch.readpointer_o !== 8'hFF) begin bad++; $display("FAIL ring_rdptr: got %h expected ff", ch.readpointer_o); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d [3];
        do_reset();
        for (int k = 0; k < 3; k++) begin
            d[k] = rand_dat();
            push_slot(k, d[k]);
        end
        tick(); tick(); tick();
        for (int c = 0; c < 10; c++) begin
            total++; if (ch.valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid: cycle %0d got %b expected 1", c, ch.valid_o); end
            total++; if (ch.data_o !== d[0]) begin bad++; $display("FAIL bp_data: cycle %0d got %h expected %h", c, ch.data_o, d[0]); end
            total++; if (ch.readpointer_o !== 8'h01) begin bad++; $display("FAIL bp_rdptr: cycle %0d got %h expected 01", c, ch.readpointer_o); end
            total++; if (ch.fill_o !== 4'd2) begin bad++; $display("FAIL bp_fill: cycle %0d got %0d expected 2", c, ch.fill_o); end
            tick();
        end
        ch.ready_i = 1'b1;
        for (int b = 1; b < 3; b++) begin
            tick();
            total++; if (ch.valid_o !== 1'b1 || ch.data_o !== d[b]) begin
                bad++; $display("FAIL bp_drain: beat %0d got v=%b %h expected v=1 %h", b, ch.valid_o, ch.data_o, d[b]);
            end
        end
        tick();
        total++; if (ch.valid_o !== 1'b0) begin bad++; $display("FAIL bp_empty: valid got %b expected 0", ch.valid_o); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] e, hold_dat;
        logic [BW-1:0] rp_exp;
        logic          hold;
        int pushed, popped, guard, target;
        do_reset();
        pushed = 0; popped = 0; hold = 1'b0; hold_dat = '0;
        for (int phase = 0; phase < 2; phase++) begin
            target = (phase == 0) ? 16 : 20;
            guard  = 0;
            while (popped < target && guard < 2000) begin
                ch.ready_i = ($urandom_range(0, 3) != 0);
                if (hold) begin
                    total++;
                    if (ch.valid_o !== 1'b1 || ch.data_o !== hold_dat) begin
                        bad++; $display("FAIL wrap_hold: got v=%b %h expected v=1 %h", ch.valid_o, ch.data_o, hold_dat);
                    end
                end
                hold     = (ch.valid_o === 1'b1) && !ch.ready_i;
                hold_dat = ch.data_o;
                if (ch.valid_o === 1'b1 && ch.ready_i) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++; $display("FAIL wrap_extra_beat: got %h expected none", ch.data_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (ch.data_o !== e) begin bad++; $display("FAIL wrap_data: beat %0d got %h expected %h", popped, ch.data_o, e); end
                    end
                    popped++;
                end
                if (pushed < target && ch.writetoken_i[src_idx] == ch.readpointer_o[src_idx]
                    && $urandom_range(0, 1) == 1) begin
                    e = rand_dat();
                    push_slot(src_idx, e);
                    exp_q.push_back(e);
                    src_idx = (src_idx + 1) % BW;
                    pushed++;
                end
                tick();
                guard++;
            end
            total++; if (guard >= 2000) begin bad++; $display("FAIL wrap_timeout: popped %0d expected %0d", popped, target); end
            ch.ready_i = 1'b0;
            hold = 1'b0;
            tick(); tick(); tick(); tick();
            rp_exp = '0;
            for (int n = 0; n < popped; n++) rp_exp[n % BW] = ~rp_exp[n % BW];
            total++; if (ch.readpointer_o !== rp_exp) begin bad++; $display("FAIL wrap_rdptr: after %0d pops got %h expected %h", popped, ch.readpointer_o, rp_exp); end
            total++; if (ch.valid_o !== 1'b0 || exp_q.size() != 0) begin
                bad++; $display("FAIL wrap_leftover: valid %b queued %0d expected 0 0", ch.valid_o, exp_q.size());
            end
        end
    endtask

    task automatic test_out_of_order();
        logic [DW-1:0] d [3];
        logic [DW-1:0] got [$];
        int seen_valid;
        do_reset();
        for (int k = 0; k < 3; k++) d[k] = rand_dat();
        ch.ready_i = 1'b1;
        push_slot(2, d[2]);
        seen_valid = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ch.valid_o !== 1'b0) seen_valid++;
        end
        total++; if (seen_valid != 0) begin bad++; $display("FAIL ooo_no_valid: got %0d valid cycles expected 0", seen_valid); end
        total++; if (ch.fill_o !== 4'd1) begin bad++; $display("FAIL ooo_fill: got %0d expected 1", ch.fill_o); end
        push_slot(0, d[0]);
        push_slot(1, d[1]);
        for (int c = 0; c < 15; c++) begin
            tick();
            if (ch.valid_o === 1'b1) got.push_back(ch.data_o);
        end
        total++; if (got.size() != 3) begin bad++; $display("FAIL ooo_count: got %0d expected 3", got.size()); end
        for (int b = 0; b < 3; b++) begin
            total++;
            if (b >= got.size() || got[b] !== d[b]) begin
                bad++; $display("FAIL ooo_order: beat %0d got %h expected %h", b, (b < got.size()) ? got[b] : '0, d[b]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] dn;
        int c;
        do_reset();
        for (int k = 0; k < 4; k++) push_slot(k, rand_dat());
        c = 0;
        while (ch.valid_o !== 1'b1 && c < 10) begin tick(); c++; end
        total++; if (ch.valid_o !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid: got %b expected 1", ch.valid_o); end
        rst = 1'b1;
        ch.writetoken_i = '0;
        tick();
        rst = 1'b0;
        total++; if (ch.valid_o !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b expected 0", ch.valid_o); end
        total++; if (ch.readpointer_o !== '0) begin bad++; $display("FAIL rmid_rdptr: got %h expected 00", ch.readpointer_o); end
        total++; if (ch.fill_o !== '0) begin bad++; $display("FAIL rmid_fill: got %0d expected 0", ch.fill_o); end
        total++; if (ch.data_o !== '0) begin bad++; $display("FAIL rmid_data: got %h expected 0", ch.data_o); end
        dn = rand_dat();
        ch.ready_i = 1'b1;
        push_slot(0, dn);
        c = 0;
        while (ch.valid_o !== 1'b1 && c < 10) begin tick(); c++; end
        total++; if (ch.valid_o !== 1'b1 || ch.data_o !== dn || ch.readpointer_o !== 8'h01) begin
            bad++; $display("FAIL rmid_restart: got v=%b %h rp=%h expected v=1 %h rp=01", ch.valid_o, ch.data_o, ch.readpointer_o, dn);
        end
    endtask

    initial begin
        rst = 1'b1;
        ch.writetoken_i  = '0;
        ch.buffer_data_i = '0;
        ch.ready_i       = 1'b0;
        src_idx = 0;
        test_reset();
        test_latency();
        test_full_ring();
        test_backpressure();
        test_wrap();
        test_out_of_order();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
